// File: rtl/sens_hispi_lanes_fifo.sv
// rtl/sens_hispi_lanes_fifo.sv - multi-lane HiSPI line FIFO with lane deskew and error flags
module sens_hispi_lanes_fifo #(
  parameter int NUM_LANES   = 4,
  parameter int DATA_WIDTH  = 12,
  parameter int DATA_DEPTH  = 4,
  parameter int COUNT_START = 7,
  parameter int SKEW_MAX    = 8
) (
  input  logic                            pclk,
  input  logic                            prst_n,
  input  logic [NUM_LANES-1:0]            we,
  input  logic [NUM_LANES-1:0]            sol,
  input  logic [NUM_LANES-1:0]            eol,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] din,
  input  logic                            re,
  output logic [NUM_LANES*DATA_WIDTH-1:0] dout,
  output logic                            dv,
  output logic                            start,
  output logic                            run,
  output logic                            ovfl,
  output logic                            unfl,
  output logic                            seq_err,
  input  logic                            clr_err
);

  localparam int AW      = DATA_DEPTH + 1;
  localparam int ENTRIES = 1 << DATA_DEPTH;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN, ST_DRAIN} state_t;

  state_t                state, state_nxt;
  logic [7:0]            skew_cnt, skew_nxt;
  logic [NUM_LANES-1:0]  sol_seen, sol_seen_nxt;
  logic [NUM_LANES-1:0]  line_run;
  logic [AW-1:0]         wa [NUM_LANES];
  logic [AW-1:0]         ra;
  logic [AW-1:0]         ra_inc;
  logic [DATA_WIDTH-1:0] mem [NUM_LANES][ENTRIES];

  logic [AW-1:0]         occ_now [NUM_LANES];
  logic [AW-1:0]         occ_nxt [NUM_LANES];
  logic [NUM_LANES-1:0]  lane_full, lane_wr, lane_drop;
  logic [NUM_LANES-1:0]  empty_now, empty_nxt, wa_ge_start;
  logic                  reading, rd_ok, rd_miss, rd_skip, drain_done;
  logic                  seq_set, kill_lines;

  assign ra_inc = ra + 1'b1;

  // Per-lane occupancy against the shared read pointer; an occupancy above
  // ENTRIES means ra has run past a short lane, which also counts as empty.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      occ_now[i]     = wa[i] - ra;
      occ_nxt[i]     = wa[i] - ra_inc;
      lane_full[i]   = (occ_now[i] == AW'(ENTRIES));
      empty_now[i]   = (occ_now[i] == '0) || (occ_now[i] > AW'(ENTRIES));
      empty_nxt[i]   = (occ_nxt[i] == '0) || (occ_nxt[i] > AW'(ENTRIES));
      wa_ge_start[i] = (wa[i] >= AW'(COUNT_START));
      lane_wr[i]     = we[i] & line_run[i] & ~sol[i] & ~lane_full[i];
      lane_drop[i]   = we[i] & line_run[i] & ~sol[i] & lane_full[i];
    end
  end

  // Read qualification; in DRAIN a read that hits a short lane still steps ra
  // so the leftover samples of longer lanes are discarded and DRAIN can end.
  always_comb begin
    reading    = (state == ST_RUN) || (state == ST_DRAIN);
    rd_ok      = reading & re & ~(|empty_now);
    rd_miss    = reading & re & (|empty_now);
    rd_skip    = rd_miss & (state == ST_DRAIN) & ~(&empty_now);
    drain_done = (rd_ok | rd_skip) ? (&empty_nxt) : (&empty_now);
  end

  // Next-state logic: line start gating, skew timeout and restart on stray sol.
  always_comb begin
    state_nxt    = state;
    skew_nxt     = skew_cnt;
    sol_seen_nxt = sol_seen;
    start        = 1'b0;
    seq_set      = 1'b0;
    kill_lines   = 1'b0;
    case (state)
      ST_IDLE: begin
        skew_nxt = '0;
        if (|sol) begin
          state_nxt    = ST_FILL;
          sol_seen_nxt = sol;
        end
      end
      ST_FILL: begin
        skew_nxt     = skew_cnt + 8'd1;
        sol_seen_nxt = sol_seen | sol;
        if ((&sol_seen) && (&wa_ge_start) && ~(|sol)) begin
          state_nxt = ST_RUN;
          start     = 1'b1;
        end else if ((skew_nxt == 8'(SKEW_MAX)) && ~(&(sol_seen | sol))) begin
          state_nxt  = ST_IDLE;
          seq_set    = 1'b1;
          kill_lines = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (|sol) begin
          state_nxt    = ST_FILL;
          seq_set      = 1'b1;
          skew_nxt     = '0;
          sol_seen_nxt = sol;
        end else if (state == ST_RUN) begin
          if (~(|line_run)) state_nxt = ST_DRAIN;
        end else if (drain_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign run = (state == ST_RUN) || (state == ST_DRAIN);

  // State register with skew counter and sol bookkeeping.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state    <= ST_IDLE;
      skew_cnt <= '0;
      sol_seen <= '0;
    end else begin
      state    <= state_nxt;
      skew_cnt <= skew_nxt;
      sol_seen <= sol_seen_nxt;
    end
  end

  // Per-lane write pointers and line_run; sol restarts a lane and wins over we.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      for (int i = 0; i < NUM_LANES; i++) wa[i] <= '0;
      line_run <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (sol[i])          wa[i] <= '0;
        else if (lane_wr[i]) wa[i] <= wa[i] + 1'b1;
        if (kill_lines)      line_run[i] <= 1'b0;
        else if (sol[i])     line_run[i] <= 1'b1;
        else if (eol[i])     line_run[i] <= 1'b0;
      end
    end
  end

  // Shared read pointer, held at zero while a line is filling.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n)                                        ra <= '0;
    else if (state == ST_FILL || state_nxt == ST_FILL) ra <= '0;
    else if (rd_ok || rd_skip)                          ra <= ra_inc;
  end

  // Lane sample storage; contents are deliberately not reset.
  always_ff @(posedge pclk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_wr[i]) mem[i][wa[i][DATA_DEPTH-1:0]] <= din[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Aligned output word; dout holds whenever no read is accepted.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      dout <= '0;
      dv   <= 1'b0;
    end else begin
      dv <= rd_ok;
      if (rd_ok) begin
        for (int i = 0; i < NUM_LANES; i++) dout[i*DATA_WIDTH +: DATA_WIDTH] <= mem[i][ra[DATA_DEPTH-1:0]];
      end
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      ovfl    <= 1'b0;
      unfl    <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      ovfl    <= (ovfl & ~clr_err) | (|lane_drop);
      unfl    <= (unfl & ~clr_err) | rd_miss;
      seq_err <= (seq_err & ~clr_err) | seq_set;
    end
  end

endmodule

// File: tb/tb_sens_hispi_lanes_fifo.sv
// tb/tb_sens_hispi_lanes_fifo.sv - directed self-checking bench for sens_hispi_lanes_fifo
module tb_sens_hispi_lanes_fifo;

  localparam int NL = 4;
  localparam int DW = 12;

  logic             pclk = 1'b0;
  logic             prst_n;
  logic [NL-1:0]    we, sol, eol;
  logic [NL*DW-1:0] din;
  logic             re;
  logic [NL*DW-1:0] dout;
  logic             dv, start, run, ovfl, unfl, seq_err;
  logic             clr_err;

  int errors = 0;
  int checks = 0;

  int lane_off [NL];
  int lane_len [NL];
  logic [NL*DW-1:0] got [$];
  int start_cyc, rise_cyc, fall_cyc, unfl_cyc, ovfl_cyc, seqerr_cyc;

  sens_hispi_lanes_fifo #(
    .NUM_LANES(NL), .DATA_WIDTH(DW), .DATA_DEPTH(4), .COUNT_START(7), .SKEW_MAX(8)
  ) dut (
    .pclk(pclk), .prst_n(prst_n), .we(we), .sol(sol), .eol(eol), .din(din),
    .re(re), .dout(dout), .dv(dv), .start(start), .run(run), .ovfl(ovfl),
    .unfl(unfl), .seq_err(seq_err), .clr_err(clr_err)
  );

  always #5 pclk = ~pclk;

  function automatic logic [NL*DW-1:0] word_of(input int n);
    logic [NL*DW-1:0] w;
    for (int i = 0; i < NL; i++) w[i*DW +: DW] = 12'(256 * i + n);
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // Drives lane_off/lane_len lines; re mode 0 = never, 1 = after start seen, 2 = always.
  // Observation label k+1 is the cycle whose inputs come next.
  task automatic drive(input int mode, input int ncyc);
    bit started;
    bit prev_run;
    int n;
    got.delete();
    start_cyc = -1; rise_cyc = -1; fall_cyc = -1;
    unfl_cyc = -1; ovfl_cyc = -1; seqerr_cyc = -1;
    started = 1'b0;
    prev_run = run;
    for (int k = 0; k < ncyc; k++) begin
      for (int i = 0; i < NL; i++) begin
        n = k - lane_off[i] - 1;
        sol[i] = (lane_off[i] >= 0) && (k == lane_off[i]);
        we[i]  = (lane_off[i] >= 0) && (n >= 0) && (n < lane_len[i]);
        eol[i] = (lane_off[i] >= 0) && (n == lane_len[i] - 1);
        din[i*DW +: DW] = we[i] ? 12'(256 * i + n) : '0;
      end
      re = (mode == 2) || (mode == 1 && started);
      @(posedge pclk);
      #1;
      if (dv) got.push_back(dout);
      if (start && start_cyc < 0) begin start_cyc = k + 1; started = 1'b1; end
      if (run && !prev_run && rise_cyc < 0) rise_cyc = k + 1;
      if (!run && prev_run && fall_cyc < 0) fall_cyc = k + 1;
      prev_run = run;
      if (unfl && unfl_cyc < 0) unfl_cyc = k + 1;
      if (ovfl && ovfl_cyc < 0) ovfl_cyc = k + 1;
      if (seq_err && seqerr_cyc < 0) seqerr_cyc = k + 1;
    end
    we = '0; sol = '0; eol = '0; din = '0; re = 1'b0;
  endtask

  task automatic test_reset;
    prst_n = 1'b0;
    idle(2);
    checks++; if (dout !== '0)    begin errors++; $display("FAIL reset_dout got=%0h exp=0", dout); end
    checks++; if (dv !== 1'b0)    begin errors++; $display("FAIL reset_dv got=%b exp=0", dv); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", start); end
    checks++; if (run !== 1'b0)   begin errors++; $display("FAIL reset_run got=%b exp=0", run); end
    checks++; if ({ovfl, unfl, seq_err} !== 3'b000)
      begin errors++; $display("FAIL reset_flags got=%b exp=000", {ovfl, unfl, seq_err}); end
    prst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic_line;
    lane_off = '{0, 0, 0, 0};
    lane_len = '{20, 20, 20, 20};
    drive(1, 40);
    checks++; if (start_cyc != 8) begin errors++; $display("FAIL basic_start_cycle got=%0d exp=8", start_cyc); end
    checks++; if (rise_cyc != 9)  begin errors++; $display("FAIL basic_run_rise got=%0d exp=9", rise_cyc); end
    checks++; if (fall_cyc != 29) begin errors++; $display("FAIL basic_run_fall got=%0d exp=29", fall_cyc); end
    checks++; if (got.size() != 20) begin errors++; $display("FAIL basic_word_count got=%0d exp=20", got.size()); end
    for (int n = 0; n < 20 && n < got.size(); n++) begin
      checks++;
      if (got[n] !== word_of(n)) begin errors++; $display("FAIL basic_word%0d got=%0h exp=%0h", n, got[n], word_of(n)); end
    end
    checks++; if (dout !== word_of(19)) begin errors++; $display("FAIL basic_dout_hold got=%0h exp=%0h", dout, word_of(19)); end
    checks++; if ({ovfl, unfl, seq_err} !== 3'b000)
      begin errors++; $display("FAIL basic_flags got=%b exp=000", {ovfl, unfl, seq_err}); end
    idle(3);
  endtask

  task automatic test_skew;
    lane_off = '{0, 2, 5, 7};
    lane_len = '{20, 20, 20, 20};
    drive(1, 45);
    checks++; if (start_cyc != 15) begin errors++; $display("FAIL skew_start_cycle got=%0d exp=15", start_cyc); end
    checks++; if (fall_cyc != 36)  begin errors++; $display("FAIL skew_run_fall got=%0d exp=36", fall_cyc); end
    checks++; if (got.size() != 20) begin errors++; $display("FAIL skew_word_count got=%0d exp=20", got.size()); end
    for (int n = 0; n < 20 && n < got.size(); n++) begin
      checks++;
      if (got[n] !== word_of(n)) begin errors++; $display("FAIL skew_word%0d got=%0h exp=%0h", n, got[n], word_of(n)); end
    end
    checks++; if ({ovfl, unfl, seq_err} !== 3'b000)
      begin errors++; $display("FAIL skew_flags got=%b exp=000", {ovfl, unfl, seq_err}); end
    idle(3);
  endtask

  task automatic test_skew_timeout;
    lane_off = '{0, 0, 0, -1};
    lane_len = '{20, 20, 20, 20};
    drive(1, 30);
    checks++; if (seqerr_cyc != 9) begin errors++; $display("FAIL timeout_seq_err_cycle got=%0d exp=9", seqerr_cyc); end
    checks++; if (start_cyc != -1) begin errors++; $display("FAIL timeout_no_start got=%0d exp=-1", start_cyc); end
    checks++; if (rise_cyc != -1)  begin errors++; $display("FAIL timeout_run_stays_low got=%0d exp=-1", rise_cyc); end
    checks++; if ({ovfl, unfl} !== 2'b00) begin errors++; $display("FAIL timeout_other_flags got=%b exp=00", {ovfl, unfl}); end
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL timeout_clr_err got=%b exp=0", seq_err); end
    idle(2);
  endtask

  task automatic test_overflow;
    lane_off = '{0, 0, 0, 0};
    lane_len = '{20, 20, 20, 20};
    drive(0, 30);
    checks++; if (start_cyc != 8)  begin errors++; $display("FAIL ovfl_start_cycle got=%0d exp=8", start_cyc); end
    checks++; if (ovfl_cyc != 18)  begin errors++; $display("FAIL ovfl_cycle got=%0d exp=18", ovfl_cyc); end
    checks++; if (run !== 1'b1)    begin errors++; $display("FAIL ovfl_run_pending got=%b exp=1", run); end
    lane_off = '{-1, -1, -1, -1};
    drive(2, 25);
    checks++; if (got.size() != 16) begin errors++; $display("FAIL ovfl_drain_count got=%0d exp=16", got.size()); end
    for (int n = 0; n < 16 && n < got.size(); n++) begin
      checks++;
      if (got[n] !== word_of(n)) begin errors++; $display("FAIL ovfl_word%0d got=%0h exp=%0h", n, got[n], word_of(n)); end
    end
    checks++; if (fall_cyc != 16) begin errors++; $display("FAIL ovfl_run_fall got=%0d exp=16", fall_cyc); end
    checks++; if (ovfl !== 1'b1)  begin errors++; $display("FAIL ovfl_sticky got=%b exp=1", ovfl); end
    checks++; if (unfl !== 1'b0)  begin errors++; $display("FAIL ovfl_no_unfl got=%b exp=0", unfl); end
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    checks++; if (ovfl !== 1'b0) begin errors++; $display("FAIL ovfl_clr got=%b exp=0", ovfl); end
    idle(2);
  endtask

  task automatic test_short_lane;
    lane_off = '{0, 0, 0, 0};
    lane_len = '{10, 12, 12, 12};
    drive(1, 35);
    checks++; if (start_cyc != 8)  begin errors++; $display("FAIL short_start_cycle got=%0d exp=8", start_cyc); end
    checks++; if (got.size() != 10) begin errors++; $display("FAIL short_word_count got=%0d exp=10", got.size()); end
    for (int n = 0; n < 10 && n < got.size(); n++) begin
      checks++;
      if (got[n] !== word_of(n)) begin errors++; $display("FAIL short_word%0d got=%0h exp=%0h", n, got[n], word_of(n)); end
    end
    checks++; if (unfl_cyc != 20) begin errors++; $display("FAIL short_unfl_cycle got=%0d exp=20", unfl_cyc); end
    checks++; if (fall_cyc != 21) begin errors++; $display("FAIL short_run_fall got=%0d exp=21", fall_cyc); end
    checks++; if ({ovfl, seq_err} !== 2'b00) begin errors++; $display("FAIL short_other_flags got=%b exp=00", {ovfl, seq_err}); end
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    checks++; if (unfl !== 1'b0) begin errors++; $display("FAIL short_unfl_clr got=%b exp=0", unfl); end
    idle(2);
  endtask

  task automatic test_reset_mid_run;
    lane_off = '{0, 0, 0, 0};
    lane_len = '{20, 20, 20, 20};
    drive(1, 14);
    checks++; if ({run, dv} !== 2'b11) begin errors++; $display("FAIL midrun_active got=%b exp=11", {run, dv}); end
    #3;
    prst_n = 1'b0;
    #1;
    checks++; if ({dv, start, run, ovfl, unfl, seq_err} !== 6'b0)
      begin errors++; $display("FAIL midrun_async_outputs got=%b exp=000000", {dv, start, run, ovfl, unfl, seq_err}); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL midrun_async_dout got=%0h exp=0", dout); end
    idle(2);
    prst_n = 1'b1;
    idle(2);
    test_basic_line();
  endtask

  initial begin
    prst_n = 1'b0;
    we = '0; sol = '0; eol = '0; din = '0; re = 1'b0; clr_err = 1'b0;
    #1;
    test_reset();
    test_basic_line();
    test_skew();
    test_skew_timeout();
    test_overflow();
    test_short_lane();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
